// File: rtl/seg_pkg.sv
// Shared types and defaults for the multiplexed 7-segment controller.
package seg_pkg;

    typedef enum logic {BLANK, SHOW} mux_state_t;

    localparam int DEF_DWELL_CYCLES = 24000;
    localparam int DEF_BLANK_CYCLES = 480;

    // Width needed to hold the longer of the two phase lengths, never below 1.
    function automatic int cnt_width(input int dwell, input int blank);
        int m;
        m = (dwell > blank) ? dwell : blank;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/seg_mux_ctrl_if.sv
// Digit-value input and display-drive outputs of the segment multiplexer.
interface seg_mux_ctrl_if #(parameter int NUM_DIGITS = 2);

    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic [3:0]              s_out;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_start;

    modport master (
        output digits_in, load,
        input  s_out, an_n, frame_start
    );

    modport slave (
        input  digits_in, load,
        output s_out, an_n, frame_start
    );

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module phase_timer #(
    parameter int             W         = 2,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VAL;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/seg_mux_ctrl.sv
// Time-multiplexes NUM_DIGITS hex digits onto one segment bus with a blanking gap
// before each digit and frame-aligned double buffering of the digit values.
//
//   state | meaning
//   BLANK | all digits dark; s_out already carries the upcoming digit's nibble
//   SHOW  | digit idx lit for DWELL_CYCLES
module seg_mux_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    seg_mux_ctrl_if.slave bus
);

    localparam int CNT_W = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

    mux_state_t                       state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]       pending_q, pending_d;
    logic [NUM_DIGITS-1:0][3:0]       active_q, active_d;
    logic [NUM_DIGITS-1:0]            an_n_q, an_n_d;
    logic [3:0]                       s_out_q, s_out_d;
    logic                             frame_start_q, frame_start_d;
    logic                             wrap;
    logic                             tc;
    logic [CNT_W-1:0]                 timer_load_val;

    // The timer reloads on its own terminal count with the length of the phase being entered.
    assign timer_load_val = (state_q == BLANK) ? DWELL_LOAD : BLANK_LOAD;

    phase_timer #(
        .W         (CNT_W),
        .RESET_VAL (BLANK_LOAD)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tc),
        .load_val (timer_load_val),
        .tc       (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BLANK;
            idx_q         <= '0;
            pending_q     <= '0;
            active_q      <= '0;
            an_n_q        <= '1;
            s_out_q       <= '0;
            frame_start_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            active_q      <= active_d;
            an_n_q        <= an_n_d;
            s_out_q       <= s_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wrap      = 1'b0;
        pending_d = bus.load ? bus.digits_in : pending_q;
        active_d  = active_q;

        case (state_q)
            BLANK: begin
                if (tc) state_d = SHOW;
            end
            SHOW: begin
                if (tc) begin
                    state_d = BLANK;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase

        // pending_d already includes a same-edge load, so that load lands directly in active.
        if (wrap) active_d = pending_d;

        // Outputs are registered from next-state values so they line up with the phase they describe.
        an_n_d        = (state_d == SHOW) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
        s_out_d       = active_d[idx_d];
        frame_start_d = wrap;
    end

    assign bus.an_n        = an_n_q;
    assign bus.s_out       = s_out_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_mux_ctrl.sv
// Directed and random-load checks of seg_mux_ctrl against a frame-arithmetic model.
module tb_seg_mux_ctrl;
    import seg_pkg::*;

    localparam int ND     = 2;
    localparam int DW     = 4;
    localparam int BL     = 2;
    localparam int PERIOD = BL + DW;
    localparam int FRAME  = ND * PERIOD;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    seg_mux_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg_mux_ctrl #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycle index since reset plus the two digit buffers.
    int         t = 0;
    bit         model_valid = 1'b0;
    logic [3:0] m_pending [ND];
    logic [3:0] m_active  [ND];
    logic [3:0] m_next    [ND];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            t = 0;
            model_valid = 1'b1;
            for (int i = 0; i < ND; i++) begin
                m_pending[i] = 4'h0;
                m_active[i]  = 4'h0;
            end
        end else if (model_valid) begin
            for (int i = 0; i < ND; i++)
                m_next[i] = bus.load ? bus.digits_in[4*i +: 4] : m_pending[i];
            if ((t + 1) % FRAME == 0)
                for (int i = 0; i < ND; i++) m_active[i] = m_next[i];
            for (int i = 0; i < ND; i++) m_pending[i] = m_next[i];
            t++;
        end
    end

    always @(negedge clk) begin : cmp
        int         pos;
        int         dig;
        bit         lit;
        logic [ND-1:0] exp_an;
        if (model_valid) begin
            pos    = t % FRAME;
            dig    = pos / PERIOD;
            lit    = (pos % PERIOD) >= BL;
            exp_an = lit ? ~(ND'(1) << dig) : '1;
            chk("an_n", 32'(bus.an_n), 32'(exp_an));
            chk("s_out", 32'(bus.s_out), 32'(m_active[dig]));
            chk("frame_start", 32'(bus.frame_start), 32'(pos == 0));
            chk("one_lit", 32'($countones(~bus.an_n) <= 1), 32'd1);
            if (dut.state_q == BLANK) chk("blank_dark", 32'(bus.an_n), 32'({ND{1'b1}}));
        end
    end

    task automatic wait_cycle(input int c);
        int guard;
        guard = 0;
        @(negedge clk);
        while (t != c && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (t != c) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_cycle: reached cycle %0d required %0d", t, c);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.digits_in = v;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load      = 1'b0;
    endtask

    initial begin
        bus.load      = 1'b0;
        bus.digits_in = '0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        wait_cycle(0);
        chk("lit_c0_an", 32'(bus.an_n), 32'h3);
        chk("lit_c0_s", 32'(bus.s_out), 32'h0);
        chk("lit_c0_fs", 32'(bus.frame_start), 32'h1);
        wait_cycle(2);
        chk("lit_c2_an", 32'(bus.an_n), 32'h2);
        wait_cycle(3);
        do_load(8'hA5);
        wait_cycle(6);
        chk("lit_c6_an", 32'(bus.an_n), 32'h3);
        wait_cycle(8);
        chk("lit_c8_an", 32'(bus.an_n), 32'h1);
        chk("lit_c8_s_old", 32'(bus.s_out), 32'h0);
        wait_cycle(12);
        chk("lit_c12_fs", 32'(bus.frame_start), 32'h1);
        chk("lit_c12_s", 32'(bus.s_out), 32'h5);
        wait_cycle(13);
        do_load(8'h12);
        wait_cycle(15);
        do_load(8'h34);
        wait_cycle(18);
        chk("lit_c18_s", 32'(bus.s_out), 32'hA);
        chk("lit_c18_an", 32'(bus.an_n), 32'h3);
        wait_cycle(24);
        chk("lit_c24_s", 32'(bus.s_out), 32'h4);
        chk("lit_c24_fs", 32'(bus.frame_start), 32'h1);
        wait_cycle(30);
        chk("lit_c30_s", 32'(bus.s_out), 32'h3);
        wait_cycle(35);
        do_load(8'h9C);
        chk("lit_c36_direct_s", 32'(bus.s_out), 32'hC);
        wait_cycle(42);
        chk("lit_c42_s", 32'(bus.s_out), 32'h9);

        wait_cycle(57);
        chk("lit_c57_an", 32'(bus.an_n), 32'h1);
        chk("lit_c57_s", 32'(bus.s_out), 32'h9);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("lit_rst_an", 32'(bus.an_n), 32'h3);
        chk("lit_rst_s", 32'(bus.s_out), 32'h0);
        chk("lit_rst_fs", 32'(bus.frame_start), 32'h1);
        wait_cycle(2);
        chk("lit_rst_c2_an", 32'(bus.an_n), 32'h2);
        chk("lit_rst_c2_s", 32'(bus.s_out), 32'h0);
        wait_cycle(8);
        chk("lit_rst_c8_an", 32'(bus.an_n), 32'h1);
        chk("lit_rst_c8_s", 32'(bus.s_out), 32'h0);

        repeat (1000) begin
            @(negedge clk);
            bus.load      = ($urandom_range(0, 3) == 0);
            bus.digits_in = 8'($urandom);
        end
        @(negedge clk);
        bus.load = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
